// File: rtl/ppu_pkg.sv
// Shared constants and state encoding for the PPU job sequencer.
package ppu_pkg;

  // Tile / vector geometry
  localparam int ROWS_PER_TILE = 16;
  localparam int TILES_PER_VEC = 4;
  localparam int TILE_GAP      = 1;
  // The PPU stays busy for one cycle per streamed row.
  localparam int PPU_BUSY_LEN  = 16;

  localparam int ROW_W  = $clog2(ROWS_PER_TILE);
  localparam int TILE_W = $clog2(TILES_PER_VEC);

  // State encoding
  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_WAIT_TILE = 3'd1;
  localparam logic [2:0] ENC_STREAM    = 3'd2;
  localparam logic [2:0] ENC_GAP       = 3'd3;
  localparam logic [2:0] ENC_QWAIT     = 3'd4;
  localparam logic [2:0] ENC_DONE      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_WAIT_TILE = ENC_WAIT_TILE,
    ST_STREAM    = ENC_STREAM,
    ST_GAP       = ENC_GAP,
    ST_QWAIT     = ENC_QWAIT,
    ST_DONE      = ENC_DONE
  } state_e;

endpackage

// File: rtl/ppu_addr_gen.sv
// Row / tile / vector counters and the accumulator read pointer.
// Rows of a job are contiguous (vec*64 + tile*16 + row), so a single
// running pointer loaded with the base and bumped on every streamed row
// yields the address; it wraps modulo 2^ACC_AW by construction.
module ppu_addr_gen
  import ppu_pkg::*;
#(
  parameter int ACC_AW = 8,
  parameter int NV_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ACC_AW-1:0] i_base,
  input  logic              i_row_inc,
  input  logic              i_tile_inc,
  input  logic              i_vec_inc,
  output logic [ACC_AW-1:0] o_addr,
  output logic [NV_W-1:0]   o_vec,
  output logic              o_first_row,
  output logic              o_last_row,
  output logic              o_last_tile
);

  logic [ACC_AW-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [NV_W-1:0]   vec_q,  vec_d;

  // Next-value logic: a job load overrides every increment.
  always_comb begin
    addr_d = addr_q;
    row_d  = row_q;
    tile_d = tile_q;
    vec_d  = vec_q;
    if (i_load) begin
      addr_d = i_base;
      row_d  = '0;
      tile_d = '0;
      vec_d  = '0;
    end else begin
      if (i_row_inc) begin
        addr_d = addr_q + 1'b1;
        row_d  = row_q + 1'b1;
      end
      if (i_tile_inc) begin
        tile_d = tile_q + 1'b1;
      end
      if (i_vec_inc) begin
        vec_d = vec_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;
      row_q  <= '0;
      tile_q <= '0;
      vec_q  <= '0;
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
      tile_q <= tile_d;
      vec_q  <= vec_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_vec       = vec_q;
  assign o_first_row = (row_q == '0);
  // A tile streams for exactly the PPU busy window.
  assign o_last_row  = (row_q == ROW_W'(PPU_BUSY_LEN - 1));
  assign o_last_tile = (tile_q == TILE_W'(TILES_PER_VEC - 1));

endmodule

// File: rtl/ppu_sched.sv
// PPU job sequencer: waits for accumulator tiles, streams 16 rows per tile
// in lock-step with the PPU busy window, releases each tile and holds the
// next vector until the quantizer reports scale factors.
module ppu_sched
  import ppu_pkg::*;
#(
  parameter int ACC_AW    = 8,
  parameter int NV_W      = 8,
  parameter int QWAIT_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_job_valid,
  output logic              o_job_ready,
  input  logic [NV_W-1:0]   i_job_nvec,
  input  logic [ACC_AW-1:0] i_job_base,
  input  logic              i_tile_valid,
  output logic              o_tile_ack,
  output logic              o_acc_rd_en,
  output logic [ACC_AW-1:0] o_acc_rd_addr,
  output logic              o_ppu_start,
  input  logic              i_sf_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [NV_W-1:0]   o_vec_idx
);

  // Counter holds 0..QWAIT_MAX-1.
  localparam int QW_W = (QWAIT_MAX < 2) ? 1 : $clog2(QWAIT_MAX);

  state_e          state_q, state_d;
  logic [NV_W-1:0] nvec_q,  nvec_d;
  logic [QW_W-1:0] qcnt_q,  qcnt_d;
  logic            err_q,   err_d;
  logic            rdy_q,   rdy_d;

  logic            load, row_inc, tile_inc, vec_inc;
  logic [NV_W-1:0] vec;
  logic [NV_W:0]   vec_plus1;
  logic            first_row, last_row, last_tile;

  ppu_addr_gen #(
    .ACC_AW (ACC_AW),
    .NV_W   (NV_W)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (load),
    .i_base      (i_job_base),
    .i_row_inc   (row_inc),
    .i_tile_inc  (tile_inc),
    .i_vec_inc   (vec_inc),
    .o_addr      (o_acc_rd_addr),
    .o_vec       (vec),
    .o_first_row (first_row),
    .o_last_row  (last_row),
    .o_last_tile (last_tile)
  );

  assign vec_plus1 = {1'b0, vec} + {{NV_W{1'b0}}, 1'b1};

  // Next-state and counter control for the job sequencer.
  always_comb begin
    state_d  = state_q;
    nvec_d   = nvec_q;
    qcnt_d   = qcnt_q;
    err_d    = err_q;
    load     = 1'b0;
    row_inc  = 1'b0;
    tile_inc = 1'b0;
    vec_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rdy_q gates acceptance so nothing is taken while reset is settling.
        if (rdy_q && i_job_valid) begin
          load   = 1'b1;
          nvec_d = i_job_nvec;
          err_d  = 1'b0;
          state_d = (i_job_nvec == '0) ? ST_DONE : ST_WAIT_TILE;
        end
      end
      ST_WAIT_TILE: begin
        if (i_tile_valid) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        row_inc = 1'b1;
        if (last_row) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Tile counter wraps to 0 after the last tile of a vector.
        tile_inc = 1'b1;
        qcnt_d   = '0;
        state_d  = last_tile ? ST_QWAIT : ST_WAIT_TILE;
      end
      ST_QWAIT: begin
        // A scale-factor report in the final allowed cycle still wins.
        if (i_sf_valid) begin
          vec_inc = 1'b1;
          state_d = (vec_plus1 == {1'b0, nvec_q}) ? ST_DONE : ST_WAIT_TILE;
        end else if (qcnt_q == QW_W'(QWAIT_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  // State and job registers; reset abandons any job in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      nvec_q  <= '0;
      qcnt_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nvec_q  <= nvec_d;
      qcnt_q  <= qcnt_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_job_ready = rdy_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_acc_rd_en = (state_q == ST_STREAM);
  assign o_ppu_start = (state_q == ST_STREAM) && first_row;
  assign o_tile_ack  = (state_q == ST_GAP);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = err_q;
  assign o_vec_idx   = vec;

endmodule

// File: tb/tb_ppu_sched.sv
// Cycle-level bench for ppu_sched: a timeline model builds the expected
// per-cycle outputs of each job from tile stalls and quantizer delays.
module tb_ppu_sched;

  localparam int MAXC = 2048;
  localparam int QMAX = 255;

  logic       i_clk, i_rst_n;
  logic       i_job_valid, o_job_ready;
  logic [7:0] i_job_nvec, i_job_base;
  logic       i_tile_valid, o_tile_ack, o_acc_rd_en, o_ppu_start;
  logic [7:0] o_acc_rd_addr, o_vec_idx;
  logic       i_sf_valid, o_busy, o_done, o_err;

  ppu_sched #(.ACC_AW(8), .NV_W(8), .QWAIT_MAX(QMAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_nvec(i_job_nvec), .i_job_base(i_job_base),
    .i_tile_valid(i_tile_valid), .o_tile_ack(o_tile_ack),
    .o_acc_rd_en(o_acc_rd_en), .o_acc_rd_addr(o_acc_rd_addr),
    .o_ppu_start(o_ppu_start), .i_sf_valid(i_sf_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_vec_idx(o_vec_idx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle outputs and per-cycle stimulus of the current job.
  bit       e_ready[MAXC], e_busy[MAXC], e_start[MAXC], e_rden[MAXC];
  bit       e_ack[MAXC], e_done[MAXC], e_err[MAXC];
  bit [7:0] e_addr[MAXC], e_vec[MAXC];
  bit       tv_a[MAXC], sf_a[MAXC], jv_a[MAXC];
  bit [7:0] nv_a[MAXC], base_a[MAXC];
  int       stall_a[64];
  int       sfd_a[16];
  int       job_len, exp_starts, first_t;
  bit [7:0] m_vec;
  bit       m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 64; i++) stall_a[i] = 0;
    for (int i = 0; i < 16; i++) sfd_a[i] = 0;
  endtask

  // Timeline model: accept at cycle 'gap'; each tile waits its stall in
  // WAIT_TILE, streams 16 rows, then one ack cycle; each vector then waits
  // sfd cycles for sf_valid (or times out after QMAX cycles).
  task automatic build_job(input int gap, input int nvec, input int base);
    int w, t, q0, d, dn;
    for (int c = 0; c < MAXC; c++) begin
      e_ready[c] = 1'b0; e_busy[c] = 1'b1; e_start[c] = 1'b0; e_rden[c] = 1'b0;
      e_ack[c] = 1'b0; e_done[c] = 1'b0; e_err[c] = 1'b0;
      e_addr[c] = 8'h00; e_vec[c] = 8'h00;
      tv_a[c] = 1'($urandom_range(0, 1));
      sf_a[c] = 1'($urandom_range(0, 1));
      jv_a[c] = 1'($urandom_range(0, 1));
      nv_a[c] = 8'($urandom);
      base_a[c] = 8'($urandom);
    end
    for (int c = 0; c <= gap; c++) begin
      e_ready[c] = 1'b1; e_busy[c] = 1'b0;
      e_err[c] = m_err; e_vec[c] = m_vec;
      jv_a[c] = (c == gap);
    end
    nv_a[gap] = 8'(nvec);
    base_a[gap] = 8'(base);
    exp_starts = 0;
    first_t = -1;
    w = gap + 1;
    dn = -1;
    if (nvec == 0) dn = gap + 1;
    for (int v = 0; v < nvec && dn < 0; v++) begin
      for (int tl = 0; tl < 4; tl++) begin
        for (int c = w; c < w + stall_a[v*4+tl]; c++) tv_a[c] = 1'b0;
        tv_a[w + stall_a[v*4+tl]] = 1'b1;
        t = w + stall_a[v*4+tl] + 1;
        if (first_t < 0) first_t = t;
        e_start[t] = 1'b1;
        exp_starts++;
        for (int k = 0; k < 16; k++) begin
          e_rden[t+k] = 1'b1;
          e_addr[t+k] = 8'((base + (v*4 + tl)*16 + k) % 256);
        end
        e_ack[t+16] = 1'b1;
        w = t + 17;
      end
      q0 = w;
      d = sfd_a[v];
      if (d < QMAX) begin
        for (int c = q0; c < q0 + d; c++) sf_a[c] = 1'b0;
        sf_a[q0+d] = 1'b1;
        for (int c = q0 + d + 1; c < MAXC; c++) e_vec[c] = 8'(v + 1);
        if (v + 1 == nvec) dn = q0 + d + 1;
        else w = q0 + d + 1;
      end else begin
        for (int c = q0; c < q0 + QMAX; c++) sf_a[c] = 1'b0;
        dn = q0 + QMAX;
        for (int c = dn; c < MAXC; c++) e_err[c] = 1'b1;
      end
    end
    e_done[dn] = 1'b1;
    e_ready[dn+1] = 1'b1;
    e_busy[dn+1] = 1'b0;
    jv_a[dn+1] = 1'b0;
    job_len = dn + 2;
    m_vec = e_vec[dn];
    m_err = e_err[dn];
  endtask

  // Compare every cycle of the job timeline; optionally tally starts/acks.
  task automatic run_job(input int ncyc, input bit full, input string name);
    int ns, na;
    logic [22:0] obs, exp;
    ns = 0;
    na = 0;
    for (int c = 0; c < ncyc; c++) begin
      obs = {o_job_ready, o_busy, o_ppu_start, o_acc_rd_en,
             (o_acc_rd_en ? o_acc_rd_addr : 8'h00),
             o_tile_ack, o_done, o_err, o_vec_idx};
      exp = {e_ready[c], e_busy[c], e_start[c], e_rden[c], e_addr[c],
             e_ack[c], e_done[c], e_err[c], e_vec[c]};
      check_eq($sformatf("%s_cyc%0d", name, c), 32'(obs), 32'(exp));
      ns += int'(o_ppu_start);
      na += int'(o_tile_ack);
      i_job_valid  = jv_a[c];
      i_job_nvec   = nv_a[c];
      i_job_base   = base_a[c];
      i_tile_valid = tv_a[c];
      i_sf_valid   = sf_a[c];
      step();
    end
    if (full) begin
      check_eq({name, "_starts"}, 32'(ns), 32'(exp_starts));
      check_eq({name, "_acks"}, 32'(na), 32'(exp_starts));
      $display("job %s: %0d cycles, %0d starts, err=%0d", name, ncyc, ns, m_err);
    end
  endtask

  task automatic do_job(input int gap, input int nvec, input int base, input string name);
    build_job(gap, nvec, base);
    run_job(job_len, 1'b1, name);
  endtask

  initial begin
    logic [22:0] obs;
    i_rst_n = 1'b0;
    i_job_valid = 1'b0; i_job_nvec = 8'h00; i_job_base = 8'h00;
    i_tile_valid = 1'b0; i_sf_valid = 1'b0;
    m_vec = 8'h00;
    m_err = 1'b0;
    #1;
    obs = {o_job_ready, o_busy, o_ppu_start, o_acc_rd_en, o_acc_rd_addr,
           o_tile_ack, o_done, o_err, o_vec_idx};
    check_eq("reset_outputs", 32'(obs), 32'h0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    check_eq("ready_after_reset", 32'(o_job_ready), 32'h1);

    // Single vector, tiles always ready, sf_valid 5 cycles after last ack.
    clear_env();
    sfd_a[0] = 4;
    do_job(2, 1, 8'h00, "one_vec");

    // Two vectors with address wrap from 0xF0.
    clear_env();
    sfd_a[0] = 6;
    sfd_a[1] = 3;
    do_job(1, 2, 8'hF0, "wrap");

    // Tile 2 withheld for 10 cycles.
    clear_env();
    stall_a[2] = 10;
    sfd_a[0] = 2;
    do_job(0, 1, 8'h5A, "stall");

    // Quantizer never answers: timeout and error.
    clear_env();
    sfd_a[0] = 1000;
    do_job(3, 2, 8'h10, "timeout");

    // Empty job clears the error; job_valid during busy is ignored.
    clear_env();
    build_job(1, 0, 8'h33);
    jv_a[2] = 1'b1;
    run_job(job_len, 1'b1, "empty");

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      int nv;
      clear_env();
      nv = int'($urandom_range(0, 3));
      for (int i = 0; i < 64; i++)
        stall_a[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
      for (int i = 0; i < 16; i++)
        sfd_a[i] = ($urandom_range(0, 9) == 0) ? 400 : int'($urandom_range(0, 12));
      do_job(int'($urandom_range(0, 3)), nv, int'($urandom_range(0, 255)),
             $sformatf("rand%0d", j));
    end

    // Asynchronous reset while streaming row 7 of the first tile.
    clear_env();
    sfd_a[0] = 3;
    build_job(0, 1, 8'h80);
    run_job(first_t + 7, 1'b0, "pre_reset");
    check_eq("row7_streaming", {30'h0, o_acc_rd_en, o_ppu_start}, 32'h2);
    #2;
    i_rst_n = 1'b0;
    #1;
    obs = {o_job_ready, o_busy, o_ppu_start, o_acc_rd_en, o_acc_rd_addr,
           o_tile_ack, o_done, o_err, o_vec_idx};
    check_eq("midjob_reset_outputs", 32'(obs), 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_vec = 8'h00;
    m_err = 1'b0;
    step();
    for (int c = 0; c < 20; c++) begin
      obs = {o_job_ready, o_busy, o_ppu_start, o_acc_rd_en, o_acc_rd_addr,
             o_tile_ack, o_done, o_err, o_vec_idx};
      check_eq($sformatf("post_reset_cyc%0d", c), 32'(obs), 32'h400000);
      i_job_valid  = 1'b0;
      i_tile_valid = 1'b1;
      i_sf_valid   = 1'($urandom_range(0, 1));
      step();
    end
    $display("reset during stream: 20 idle cycles observed");

    // A normal job after the abandoned one.
    clear_env();
    sfd_a[0] = 1;
    do_job(0, 1, 8'h00, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
